// File: rtl/ddr2_cmd_arbiter_pkg.sv
// ============================================================================
// Module      : ddr2_cmd_arbiter_pkg
// Description : Shared constants and types for the DDR2 command-bus arbiter.
//               DDR2 command codes, default widths, refresh timing and FSM
//               state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr2_cmd_arbiter_pkg;

    // Default bus widths
    localparam int DEF_BA_BITS   = 3;
    localparam int DEF_ADDR_BITS = 14;

    // Refresh timing: 7.8us average refresh interval at a 5ns clock period
    localparam int TREFI_PS      = 7_800_000;
    localparam int TCK_PS        = 5_000;
    localparam int DEF_TREFI_CYC = TREFI_PS / TCK_PS;
    localparam int DEF_MAX_OWED  = 8;

    // DDR2 command codes, encoded as {cs_n, ras_n, cas_n, we_n}
    typedef logic [3:0] cmd_t;
    localparam cmd_t CMD_NOP  = 4'b0111;
    localparam cmd_t CMD_PRE  = 4'b0010;
    localparam cmd_t CMD_AREF = 4'b0001;
    localparam cmd_t CMD_LM   = 4'b0000;
    localparam cmd_t CMD_ACT  = 4'b0011;
    localparam cmd_t CMD_RD   = 4'b0101;
    localparam cmd_t CMD_WR   = 4'b0100;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_G_REF = 3'd2,
        ST_G_WR  = 3'd3,
        ST_G_RD  = 3'd4
    } arb_state_t;

    // Last data engine served, for write/read round-robin
    typedef enum logic {
        RR_WR = 1'b0,
        RR_RD = 1'b1
    } rr_sel_t;

endpackage

`default_nettype wire

// File: rtl/ddr2_cmd_arbiter_if.sv
// ============================================================================
// Module      : ddr2_cmd_arbiter_if
// Description : Bundle of engine-side and PHY-side command bus signals around
//               the DDR2 command arbiter. The arbiter uses the slave view; the
//               init/refresh/rw engines and PHY side use the master view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ddr2_cmd_arbiter_if #(
    parameter int BA_BITS   = 3,
    parameter int ADDR_BITS = 14
);
    import ddr2_cmd_arbiter_pkg::*;

    // Init sequencer
    logic                 init_cke;
    cmd_t                 init_cmd;
    logic [BA_BITS-1:0]   init_ba;
    logic [ADDR_BITS-1:0] init_addr;
    logic                 init_end;

    // Refresh engine
    logic                 ref_req;
    logic                 ref_gnt;
    logic                 ref_done;
    cmd_t                 ref_cmd;
    logic [BA_BITS-1:0]   ref_ba;
    logic [ADDR_BITS-1:0] ref_addr;

    // Write engine
    logic                 wr_req;
    logic                 wr_gnt;
    logic                 wr_done;
    cmd_t                 wr_cmd;
    logic [BA_BITS-1:0]   wr_ba;
    logic [ADDR_BITS-1:0] wr_addr;

    // Read engine
    logic                 rd_req;
    logic                 rd_gnt;
    logic                 rd_done;
    cmd_t                 rd_cmd;
    logic [BA_BITS-1:0]   rd_ba;
    logic [ADDR_BITS-1:0] rd_addr;

    // PHY command register and status
    logic                 ddr_cke;
    cmd_t                 ddr_cmd;
    logic [BA_BITS-1:0]   ddr_ba;
    logic [ADDR_BITS-1:0] ddr_addr;
    logic                 ref_ovf;

    modport slave (
        input  init_cke, init_cmd, init_ba, init_addr, init_end,
        input  ref_done, ref_cmd, ref_ba, ref_addr,
        input  wr_req, wr_done, wr_cmd, wr_ba, wr_addr,
        input  rd_req, rd_done, rd_cmd, rd_ba, rd_addr,
        output ref_req, ref_gnt, wr_gnt, rd_gnt,
        output ddr_cke, ddr_cmd, ddr_ba, ddr_addr, ref_ovf
    );

    modport master (
        output init_cke, init_cmd, init_ba, init_addr, init_end,
        output ref_done, ref_cmd, ref_ba, ref_addr,
        output wr_req, wr_done, wr_cmd, wr_ba, wr_addr,
        output rd_req, rd_done, rd_cmd, rd_ba, rd_addr,
        input  ref_req, ref_gnt, wr_gnt, rd_gnt,
        input  ddr_cke, ddr_cmd, ddr_ba, ddr_addr, ref_ovf
    );

endinterface

`default_nettype wire

// File: rtl/ddr2_ref_timer.sv
// ============================================================================
// Module      : ddr2_ref_timer
// Description : tREFI interval timer plus count of owed (postponed) refreshes.
//               Raises ref_req while any refresh is owed and a sticky overflow
//               flag when an interval elapses with the owed count saturated.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr2_ref_timer
    import ddr2_cmd_arbiter_pkg::*;
#(
    parameter int TREFI_CYC = DEF_TREFI_CYC,
    parameter int MAX_OWED  = DEF_MAX_OWED
) (
    input  logic ck_i,
    input  logic rst_i,
    input  logic en_i,        // timer runs only once init is complete
    input  logic ref_done_i,  // qualified: refresh engine held the bus
    output logic ref_req_o,
    output logic ref_ovf_o
);

    localparam int TW = (TREFI_CYC > 1) ? $clog2(TREFI_CYC) : 1;
    localparam int OW = $clog2(MAX_OWED + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TREFI_CYC - 1);
    localparam logic [OW-1:0] OWED_MAX  = OW'(MAX_OWED);

    logic [TW-1:0] timer_q, timer_d;
    logic [OW-1:0] owed_q,  owed_d;
    logic          ovf_q,   ovf_d;
    logic          w_tick;

    // Interval counter wrap generates a tick; owed count tracks ticks minus
    // completed refreshes, saturating so a missed tick only flags overflow.
    always_comb begin
        w_tick  = en_i && (timer_q == TIMER_MAX);
        timer_d = timer_q;
        owed_d  = owed_q;
        ovf_d   = ovf_q | (w_tick && (owed_q == OWED_MAX));
        if (en_i) begin
            timer_d = w_tick ? '0 : timer_q + 1'b1;
        end
        if (w_tick && !ref_done_i) begin
            if (owed_q != OWED_MAX) begin
                owed_d = owed_q + 1'b1;
            end
        end else if (!w_tick && ref_done_i && (owed_q != '0)) begin
            owed_d = owed_q - 1'b1;
        end
    end

    // Timer, owed count and overflow flag registers
    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q <= '0;
            owed_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            owed_q  <= owed_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ref_req_o = (owed_q != '0);
    assign ref_ovf_o = ovf_q;

endmodule

`default_nettype wire

// File: rtl/ddr2_cmd_arbiter.sv
// ============================================================================
// Module      : ddr2_cmd_arbiter
// Description : Owner of the DDR2 command bus {cke,cmd,ba,addr}. Passes the
//               init sequencer through until init_end, then arbitrates the
//               bus between refresh (highest priority), write and read
//               engines with write/read round-robin. All PHY-side outputs are
//               registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr2_cmd_arbiter
    import ddr2_cmd_arbiter_pkg::*;
#(
    parameter int BA_BITS   = DEF_BA_BITS,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int TREFI_CYC = DEF_TREFI_CYC,
    parameter int MAX_OWED  = DEF_MAX_OWED
) (
    input  logic               ck_i,
    input  logic               rst_i,
    ddr2_cmd_arbiter_if.slave  bus
);

    arb_state_t           state_q,    state_d;
    rr_sel_t              rr_last_q,  rr_last_d;
    logic                 ddr_cke_q,  ddr_cke_d;
    cmd_t                 ddr_cmd_q,  ddr_cmd_d;
    logic [BA_BITS-1:0]   ddr_ba_q,   ddr_ba_d;
    logic [ADDR_BITS-1:0] ddr_addr_q, ddr_addr_d;

    logic w_ref_req;
    logic w_ref_ovf;
    logic w_ref_done_vld;
    logic w_timer_en;

    // A done pulse only counts while its engine actually holds the bus
    assign w_ref_done_vld = bus.ref_done && (state_q == ST_G_REF);
    assign w_timer_en     = (state_q != ST_INIT);

    ddr2_ref_timer #(
        .TREFI_CYC (TREFI_CYC),
        .MAX_OWED  (MAX_OWED)
    ) u_ref_timer (
        .ck_i       (ck_i),
        .rst_i      (rst_i),
        .en_i       (w_timer_en),
        .ref_done_i (w_ref_done_vld),
        .ref_req_o  (w_ref_req),
        .ref_ovf_o  (w_ref_ovf)
    );

    // Next-state, arbitration and output-mux selection
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        ddr_cke_d  = 1'b1;
        ddr_cmd_d  = CMD_NOP;
        ddr_ba_d   = ddr_ba_q;
        ddr_addr_d = ddr_addr_q;
        case (state_q)
            ST_INIT: begin
                ddr_cke_d  = bus.init_cke;
                ddr_cmd_d  = bus.init_cmd;
                ddr_ba_d   = bus.init_ba;
                ddr_addr_d = bus.init_addr;
                if (bus.init_end) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_ref_req) begin
                    state_d = ST_G_REF;
                end else if (bus.wr_req && (!bus.rd_req || (rr_last_q == RR_RD))) begin
                    state_d = ST_G_WR;
                end else if (bus.rd_req) begin
                    state_d = ST_G_RD;
                end
            end
            ST_G_REF: begin
                if (bus.ref_done) begin
                    state_d = ST_IDLE;
                end else begin
                    ddr_cmd_d  = bus.ref_cmd;
                    ddr_ba_d   = bus.ref_ba;
                    ddr_addr_d = bus.ref_addr;
                end
            end
            ST_G_WR: begin
                if (bus.wr_done) begin
                    state_d   = ST_IDLE;
                    rr_last_d = RR_WR;
                end else begin
                    ddr_cmd_d  = bus.wr_cmd;
                    ddr_ba_d   = bus.wr_ba;
                    ddr_addr_d = bus.wr_addr;
                end
            end
            ST_G_RD: begin
                if (bus.rd_done) begin
                    state_d   = ST_IDLE;
                    rr_last_d = RR_RD;
                end else begin
                    ddr_cmd_d  = bus.rd_cmd;
                    ddr_ba_d   = bus.rd_ba;
                    ddr_addr_d = bus.rd_addr;
                end
            end
            default: begin
                state_d   = ST_INIT;
                ddr_cke_d = 1'b0;
            end
        endcase
    end

    // State, round-robin pointer and PHY command register
    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            rr_last_q  <= RR_RD;
            ddr_cke_q  <= 1'b0;
            ddr_cmd_q  <= CMD_NOP;
            ddr_ba_q   <= '0;
            ddr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            ddr_cke_q  <= ddr_cke_d;
            ddr_cmd_q  <= ddr_cmd_d;
            ddr_ba_q   <= ddr_ba_d;
            ddr_addr_q <= ddr_addr_d;
        end
    end

    // Grants decode directly from the state register so reset drops them at once
    assign bus.ref_gnt  = (state_q == ST_G_REF);
    assign bus.wr_gnt   = (state_q == ST_G_WR);
    assign bus.rd_gnt   = (state_q == ST_G_RD);
    assign bus.ref_req  = w_ref_req;
    assign bus.ref_ovf  = w_ref_ovf;
    assign bus.ddr_cke  = ddr_cke_q;
    assign bus.ddr_cmd  = ddr_cmd_q;
    assign bus.ddr_ba   = ddr_ba_q;
    assign bus.ddr_addr = ddr_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr2_cmd_arbiter.sv
// ============================================================================
// Module      : tb_ddr2_cmd_arbiter
// Description : Directed self-checking bench for ddr2_cmd_arbiter with a
//               16-cycle refresh interval.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr2_cmd_arbiter;
    import ddr2_cmd_arbiter_pkg::*;

    logic ck;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    ddr2_cmd_arbiter_if #(.BA_BITS(3), .ADDR_BITS(14)) bus ();

    ddr2_cmd_arbiter #(
        .BA_BITS   (3),
        .ADDR_BITS (14),
        .TREFI_CYC (16),
        .MAX_OWED  (8)
    ) dut (
        .ck_i  (ck),
        .rst_i (rst),
        .bus   (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic clear_inputs();
        bus.init_cke = 1'b0; bus.init_cmd = CMD_NOP; bus.init_ba = '0; bus.init_addr = '0;
        bus.init_end = 1'b0;
        bus.ref_done = 1'b0; bus.ref_cmd = CMD_NOP; bus.ref_ba = '0; bus.ref_addr = '0;
        bus.wr_req = 1'b0; bus.wr_done = 1'b0; bus.wr_cmd = CMD_NOP; bus.wr_ba = '0; bus.wr_addr = '0;
        bus.rd_req = 1'b0; bus.rd_done = 1'b0; bus.rd_cmd = CMD_NOP; bus.rd_ba = '0; bus.rd_addr = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // init_end is sampled on the next edge (E0); afterwards state is IDLE, timer 0
    task automatic do_init(input logic wr, input logic rd);
        bus.init_cke = 1'b1;
        bus.init_end = 1'b1;
        bus.wr_req   = wr;
        bus.rd_req   = rd;
        step();
        bus.init_end = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({bus.ddr_cke, bus.ddr_cmd, bus.ddr_ba, bus.ddr_addr} !== {1'b0, CMD_NOP, 3'b000, 14'h0000}) begin
            errors++;
            $display("FAIL reset_bus: got cke=%b cmd=%b ba=%b addr=%h expected 0/0111/000/0000",
                     bus.ddr_cke, bus.ddr_cmd, bus.ddr_ba, bus.ddr_addr);
        end
        checks++;
        if ({bus.ref_gnt, bus.wr_gnt, bus.rd_gnt, bus.ref_req, bus.ref_ovf} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags: got gnt/req/ovf=%b expected 00000",
                     {bus.ref_gnt, bus.wr_gnt, bus.rd_gnt, bus.ref_req, bus.ref_ovf});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_init_passthru();
        do_reset();
        bus.wr_req    = 1'b1;
        bus.rd_req    = 1'b1;
        bus.init_cke  = 1'b1;
        bus.init_cmd  = CMD_LM;
        bus.init_ba   = 3'b010;
        bus.init_addr = 14'h0123;
        step();
        checks++;
        if ({bus.ddr_cke, bus.ddr_cmd, bus.ddr_ba, bus.ddr_addr} !== {1'b1, CMD_LM, 3'b010, 14'h0123}) begin
            errors++;
            $display("FAIL init_pass: got cke=%b cmd=%b ba=%b addr=%h expected 1/0000/010/0123",
                     bus.ddr_cke, bus.ddr_cmd, bus.ddr_ba, bus.ddr_addr);
        end
        bus.init_cmd = CMD_PRE;
        step();
        step();
        checks++;
        if (bus.ddr_cmd !== CMD_PRE) begin
            errors++;
            $display("FAIL init_pass2: got cmd=%b expected %b", bus.ddr_cmd, CMD_PRE);
        end
        checks++;
        if ({bus.ref_gnt, bus.wr_gnt, bus.rd_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL init_nognt: got gnts=%b expected 000", {bus.ref_gnt, bus.wr_gnt, bus.rd_gnt});
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
    endtask

    task automatic test_refresh();
        do_reset();
        do_init(1'b0, 1'b0);                      // E0
        bus.init_cke = 1'b0;                      // ignored after init
        bus.init_cmd = CMD_LM;
        bus.init_end = 1'b1;                      // later toggles ignored
        step();                                   // E1
        checks++;
        if ({bus.ddr_cke, bus.ddr_cmd} !== {1'b1, CMD_NOP}) begin
            errors++;
            $display("FAIL idle_bus: got cke=%b cmd=%b expected 1/0111", bus.ddr_cke, bus.ddr_cmd);
        end
        bus.init_end = 1'b0;
        repeat (14) step();                       // E15
        checks++;
        if (bus.ref_req !== 1'b0) begin
            errors++;
            $display("FAIL ref_early: got ref_req=%b expected 0", bus.ref_req);
        end
        step();                                   // E16: tick
        checks++;
        if ({bus.ref_req, bus.ref_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL ref_tick: got req/gnt=%b expected 10", {bus.ref_req, bus.ref_gnt});
        end
        bus.ref_cmd  = CMD_AREF;
        bus.ref_addr = 14'h0400;
        step();                                   // E17
        checks++;
        if ({bus.ref_gnt, bus.wr_gnt, bus.rd_gnt} !== 3'b100) begin
            errors++;
            $display("FAIL ref_gnt: got gnts=%b expected 100", {bus.ref_gnt, bus.wr_gnt, bus.rd_gnt});
        end
        step();                                   // E18
        checks++;
        if ({bus.ddr_cmd, bus.ddr_addr} !== {CMD_AREF, 14'h0400}) begin
            errors++;
            $display("FAIL ref_bus: got cmd=%b addr=%h expected 0001/0400", bus.ddr_cmd, bus.ddr_addr);
        end
        bus.ref_done = 1'b1;
        step();                                   // E19
        bus.ref_done = 1'b0;
        checks++;
        if ({bus.ref_gnt, bus.ref_req, bus.ddr_cmd, bus.ddr_cke} !== {2'b00, CMD_NOP, 1'b1}) begin
            errors++;
            $display("FAIL ref_done: got gnt=%b req=%b cmd=%b cke=%b expected 0/0/0111/1",
                     bus.ref_gnt, bus.ref_req, bus.ddr_cmd, bus.ddr_cke);
        end
    endtask

    task automatic test_round_robin();
        logic exp_wr;
        do_reset();
        bus.wr_cmd = CMD_WR; bus.wr_ba = 3'd1; bus.wr_addr = 14'h0AAA;
        bus.rd_cmd = CMD_RD; bus.rd_ba = 3'd6; bus.rd_addr = 14'h1555;
        do_init(1'b1, 1'b1);                      // E0
        step();                                   // E1: first grant
        for (int k = 0; k < 4; k++) begin
            exp_wr = ((k % 2) == 0);
            checks++;
            if ({bus.ref_gnt, bus.wr_gnt, bus.rd_gnt} !== {1'b0, exp_wr, ~exp_wr}) begin
                errors++;
                $display("FAIL rr_gnt%0d: got gnts=%b expected %b", k,
                         {bus.ref_gnt, bus.wr_gnt, bus.rd_gnt}, {1'b0, exp_wr, ~exp_wr});
            end
            step();
            step();
            checks++;
            if ({bus.ddr_cmd, bus.ddr_ba} !== (exp_wr ? {CMD_WR, 3'd1} : {CMD_RD, 3'd6})) begin
                errors++;
                $display("FAIL rr_bus%0d: got cmd=%b ba=%b", k, bus.ddr_cmd, bus.ddr_ba);
            end
            if (exp_wr) bus.wr_done = 1'b1;
            else        bus.rd_done = 1'b1;
            step();
            bus.wr_done = 1'b0;
            bus.rd_done = 1'b0;
            checks++;
            if ({bus.wr_gnt, bus.rd_gnt, bus.ddr_cmd} !== {2'b00, CMD_NOP}) begin
                errors++;
                $display("FAIL rr_rel%0d: got gnts=%b cmd=%b expected 00/0111", k,
                         {bus.wr_gnt, bus.rd_gnt}, bus.ddr_cmd);
            end
            step();
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        do_init(1'b1, 1'b0);                      // E0
        step();                                   // E1: G_WR
        bus.wr_req = 1'b0;                        // dropping req while granted is ignored
        bus.rd_req = 1'b1;
        step();                                   // E2
        checks++;
        if ({bus.ref_gnt, bus.wr_gnt, bus.rd_gnt} !== 3'b010) begin
            errors++;
            $display("FAIL pri_hold: got gnts=%b expected 010", {bus.ref_gnt, bus.wr_gnt, bus.rd_gnt});
        end
        repeat (14) step();                       // E16: refresh now owed
        bus.ref_done = 1'b1;                      // not granted: must be ignored
        step();                                   // E17
        bus.ref_done = 1'b0;
        checks++;
        if ({bus.ref_req, bus.ref_gnt, bus.wr_gnt, bus.rd_gnt} !== 4'b1010) begin
            errors++;
            $display("FAIL pri_wrkeep: got req/gnts=%b expected 1010",
                     {bus.ref_req, bus.ref_gnt, bus.wr_gnt, bus.rd_gnt});
        end
        bus.wr_done = 1'b1;
        step();                                   // E18: IDLE
        bus.wr_done = 1'b0;
        step();                                   // E19
        checks++;
        if ({bus.ref_gnt, bus.wr_gnt, bus.rd_gnt} !== 3'b100) begin
            errors++;
            $display("FAIL pri_ref: got gnts=%b expected 100", {bus.ref_gnt, bus.wr_gnt, bus.rd_gnt});
        end
        bus.ref_done = 1'b1;
        step();                                   // E20
        bus.ref_done = 1'b0;
        step();                                   // E21
        checks++;
        if ({bus.ref_req, bus.ref_gnt, bus.wr_gnt, bus.rd_gnt} !== 4'b0001) begin
            errors++;
            $display("FAIL pri_rd: got req/gnts=%b expected 0001",
                     {bus.ref_req, bus.ref_gnt, bus.wr_gnt, bus.rd_gnt});
        end
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
        bus.rd_req  = 1'b0;
    endtask

    task automatic test_postpone();
        do_reset();
        do_init(1'b1, 1'b0);                      // E0
        step();                                   // E1: G_WR held
        repeat (127) step();                      // E128: 8th tick
        checks++;
        if ({bus.ref_req, bus.ref_ovf, bus.wr_gnt, dut.u_ref_timer.owed_q} !== {3'b101, 4'd8}) begin
            errors++;
            $display("FAIL pp_owed8: got req=%b ovf=%b gnt=%b owed=%0d expected 1/0/1/8",
                     bus.ref_req, bus.ref_ovf, bus.wr_gnt, dut.u_ref_timer.owed_q);
        end
        repeat (15) step();                       // E143
        checks++;
        if (bus.ref_ovf !== 1'b0) begin
            errors++;
            $display("FAIL pp_noovf: got ovf=%b expected 0", bus.ref_ovf);
        end
        step();                                   // E144: 9th tick at saturation
        checks++;
        if ({bus.ref_ovf, bus.wr_gnt, dut.u_ref_timer.owed_q} !== {2'b11, 4'd8}) begin
            errors++;
            $display("FAIL pp_ovf: got ovf=%b gnt=%b owed=%0d expected 1/1/8",
                     bus.ref_ovf, bus.wr_gnt, dut.u_ref_timer.owed_q);
        end
        bus.wr_done = 1'b1;
        bus.wr_req  = 1'b0;
        step();                                   // E145: IDLE
        bus.wr_done = 1'b0;
        step();                                   // E146: G_REF
        bus.ref_done = 1'b1;
        step();                                   // E147
        bus.ref_done = 1'b0;
        checks++;
        if ({bus.ref_req, bus.ref_ovf, bus.ref_gnt, dut.u_ref_timer.owed_q} !== {3'b110, 4'd7}) begin
            errors++;
            $display("FAIL pp_owed7: got req=%b ovf=%b gnt=%b owed=%0d expected 1/1/0/7",
                     bus.ref_req, bus.ref_ovf, bus.ref_gnt, dut.u_ref_timer.owed_q);
        end
        step();                                   // E148: still owed
        checks++;
        if ({bus.ref_gnt, bus.ref_ovf} !== 2'b11) begin
            errors++;
            $display("FAIL pp_regrant: got gnt=%b ovf=%b expected 1/1", bus.ref_gnt, bus.ref_ovf);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus.rd_cmd = CMD_RD;
        bus.rd_ba  = 3'd6;
        do_init(1'b0, 1'b1);                      // E0
        step();                                   // E1: G_RD
        step();                                   // E2
        checks++;
        if ({bus.rd_gnt, bus.ddr_cke, bus.ddr_cmd} !== {2'b11, CMD_RD}) begin
            errors++;
            $display("FAIL mid_pre: got gnt=%b cke=%b cmd=%b expected 1/1/0101",
                     bus.rd_gnt, bus.ddr_cke, bus.ddr_cmd);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.rd_gnt, bus.ddr_cke, bus.ddr_cmd, bus.ddr_ba} !== {2'b00, CMD_NOP, 3'b000}) begin
            errors++;
            $display("FAIL mid_rst: got gnt=%b cke=%b cmd=%b ba=%b expected 0/0/0111/000",
                     bus.rd_gnt, bus.ddr_cke, bus.ddr_cmd, bus.ddr_ba);
        end
        step();
        rst = 1'b0;
        bus.init_cmd = CMD_PRE;
        step();
        step();
        checks++;
        if ({bus.rd_gnt, bus.ddr_cmd} !== {1'b0, CMD_PRE}) begin
            errors++;
            $display("FAIL mid_init: got gnt=%b cmd=%b expected 0/0010", bus.rd_gnt, bus.ddr_cmd);
        end
        bus.rd_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_init_passthru();
        test_refresh();
        test_round_robin();
        test_priority();
        test_postpone();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
